// File: rtl/zube_pkg.sv
// Shared definitions for the Z80 I/O bus master: register offsets, command
// and status field positions, and the bus-cycle state encoding.
package zube_pkg;

  localparam logic [31:0] CMD_OFFSET    = 32'h0;
  localparam logic [31:0] RESULT_OFFSET = 32'h4;
  localparam logic [31:0] STATUS_OFFSET = 32'h8;

  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = 8;
  localparam int DIR_BIT  = 16;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } zube_state_e;

endpackage

// File: rtl/zube_phase_counter.sv
// Loadable 8-bit down-counter; tc is high while the count sits at zero, so a
// load of N-1 gives a phase of exactly N cycles.
module zube_phase_counter
  import zube_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] count,
  output logic       tc
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == 8'd0);

endmodule

// File: rtl/zube_io_master.sv
// Wishbone-controlled initiator for Z80 IN/OUT cycles: one command register
// launches a timed setup/strobe/hold cycle and read data lands in RESULT.
module zube_io_master
  import zube_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_1000,
  parameter logic [31:0] CMD_ADDRESS    = BASE_ADDRESS + CMD_OFFSET,
  parameter logic [31:0] RESULT_ADDRESS = BASE_ADDRESS + RESULT_OFFSET,
  parameter logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + STATUS_OFFSET,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic        wb_stall_out,
  output logic [31:0] wb_data_out,
  output logic [7:0]  z80_address_bus,
  output logic [7:0]  z80_data_bus_out,
  input  logic [7:0]  z80_data_bus_in,
  output logic        z80_bus_dir,
  output logic        z80_write_strobe_b,
  output logic        z80_read_strobe_b
);

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  zube_state_e state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        dir_q, dir_d;
  logic [7:0]  sync_q, sync_d;
  logic [7:0]  result_q, result_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cnt_load;
  logic [7:0]  cnt_value;
  logic [7:0]  cnt_count;
  logic        cnt_tc;

  logic        wb_req, hit_cmd, hit_result, hit_status, hit_any;
  logic        cmd_accept, cmd_drop, busy;
  logic [31:0] status_word;

  zube_phase_counter u_phase_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .count      (cnt_count),
    .tc         (cnt_tc)
  );

  always_comb begin
    wb_req     = wb_cyc_in && wb_stb_in;
    hit_cmd    = wb_req && (wb_addr_in == CMD_ADDRESS);
    hit_result = wb_req && (wb_addr_in == RESULT_ADDRESS);
    hit_status = wb_req && (wb_addr_in == STATUS_ADDRESS);
    hit_any    = hit_cmd || hit_result || hit_status;
    busy       = (state_q != IDLE);
    cmd_accept = hit_cmd && wb_we_in && !busy;
    cmd_drop   = hit_cmd && wb_we_in && busy;

    status_word               = 32'd0;
    status_word[STAT_BUSY]    = busy;
    status_word[STAT_DONE]    = done_q;
    status_word[STAT_OVERRUN] = overrun_q;

    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dir_d     = dir_q;
    sync_d    = z80_data_bus_in;
    result_d  = result_q;
    cnt_load  = 1'b0;
    cnt_value = 8'd0;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d    = wb_data_in[ADDR_LSB +: 8];
          wdata_d   = wb_data_in[DATA_LSB +: 8];
          dir_d     = wb_data_in[DIR_BIT];
          state_d   = SETUP;
          cnt_load  = 1'b1;
          cnt_value = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_tc) begin
          state_d   = STROBE;
          cnt_load  = 1'b1;
          cnt_value = STROBE_LOAD;
        end
      end
      STROBE: begin
        if (cnt_tc) begin
          state_d   = HOLD;
          cnt_load  = 1'b1;
          cnt_value = HOLD_LOAD;
          if (!dir_q) begin
            result_d = sync_q;
          end
        end
      end
      HOLD: begin
        if (cnt_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Priority ordering: the later assignment wins the race.
    done_d = done_q;
    if ((hit_result && !wb_we_in) || cmd_accept) done_d = 1'b0;
    if (state_q == HOLD && cnt_tc) done_d = 1'b1;

    overrun_d = overrun_q;
    if (hit_status && wb_we_in && wb_data_in[STAT_OVERRUN]) overrun_d = 1'b0;
    if (cmd_drop) overrun_d = 1'b1;

    ack_d   = hit_any;
    rdata_d = rdata_q;
    if (hit_any && !wb_we_in) begin
      if (hit_cmd)         rdata_d = {15'd0, dir_q, wdata_q, addr_q};
      else if (hit_result) rdata_d = {24'd0, result_q};
      else                 rdata_d = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      dir_q     <= 1'b0;
      sync_q    <= 8'h00;
      result_q  <= 8'h00;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dir_q     <= dir_d;
      sync_q    <= sync_d;
      result_q  <= result_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wb_ack_out         = ack_q;
  assign wb_stall_out       = 1'b0;
  assign wb_data_out        = rdata_q;
  assign z80_address_bus    = addr_q;
  assign z80_data_bus_out   = wdata_q;
  assign z80_bus_dir        = busy && dir_q;
  assign z80_write_strobe_b = !((state_q == STROBE) && dir_q);
  assign z80_read_strobe_b  = !((state_q == STROBE) && !dir_q);

endmodule

// File: tb/tb_zube_io_master.sv
// Self-checking bench for zube_io_master: directed vector table, randomized
// commands against a cycle-position model, and multi-cycle corner sequences.
module tb_zube_io_master;

  localparam logic [31:0] BASE   = 32'h3000_1000;
  localparam logic [31:0] CMD_A  = BASE;
  localparam logic [31:0] RES_A  = BASE + 32'd4;
  localparam logic [31:0] STAT_A = BASE + 32'd8;
  localparam logic [31:0] UNM_A  = BASE + 32'd12;
  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;
  localparam int N = S + T + H;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_in, wb_stb_in, wb_we_in;
  logic [31:0] wb_addr_in, wb_data_in;
  logic        wb_ack_out, wb_stall_out;
  logic [31:0] wb_data_out;
  logic [7:0]  z80_address_bus, z80_data_bus_out, z80_data_bus_in;
  logic        z80_bus_dir, z80_write_strobe_b, z80_read_strobe_b;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] periph_reg = 8'h00;
  logic [7:0] model_result;

  typedef struct {
    logic [31:0] cmd;
    logic [7:0]  din;
    logic [7:0]  exp_result;
    logic [31:0] exp_cmd_rb;
  } vec_t;

  vec_t table_v [6];

  zube_io_master #(
    .BASE_ADDRESS  (BASE),
    .SETUP_CYCLES  (S),
    .STROBE_CYCLES (T),
    .HOLD_CYCLES   (H)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .wb_cyc_in          (wb_cyc_in),
    .wb_stb_in          (wb_stb_in),
    .wb_we_in           (wb_we_in),
    .wb_addr_in         (wb_addr_in),
    .wb_data_in         (wb_data_in),
    .wb_ack_out         (wb_ack_out),
    .wb_stall_out       (wb_stall_out),
    .wb_data_out        (wb_data_out),
    .z80_address_bus    (z80_address_bus),
    .z80_data_bus_out   (z80_data_bus_out),
    .z80_data_bus_in    (z80_data_bus_in),
    .z80_bus_dir        (z80_bus_dir),
    .z80_write_strobe_b (z80_write_strobe_b),
    .z80_read_strobe_b  (z80_read_strobe_b)
  );

  always #5 clk = ~clk;

  // Minimal stand-in for the Z80 peripheral: latch data on the strobe's rising edge.
  always @(posedge z80_write_strobe_b) begin
    if (z80_address_bus == 8'h80) periph_reg = z80_data_bus_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1;
    wb_addr_in = addr; wb_data_in = data;
    @(posedge clk); #1;
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b0; wb_addr_in = addr;
    @(posedge clk); #1;
    check({name, "_ack"}, 32'(wb_ack_out), 32'd1);
    check(name, wb_data_out, exp);
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
  endtask

  function automatic logic [31:0] pins();
    return 32'({z80_address_bus, z80_data_bus_out, z80_bus_dir,
                z80_write_strobe_b, z80_read_strobe_b});
  endfunction

  // Expected pins k cycles after the accepting edge (k = 1..N busy, N+1 idle).
  function automatic logic [31:0] model_pins(input logic [31:0] cmd, input int k);
    logic wr, in_cycle, in_strobe;
    wr        = cmd[16];
    in_cycle  = (k >= 1) && (k <= N);
    in_strobe = (k > S) && (k <= S + T);
    return 32'({cmd[7:0], cmd[15:8], wr && in_cycle,
                !(wr && in_strobe), !(!wr && in_strobe)});
  endfunction

  task automatic run_cmd(input logic [31:0] cmd);
    wb_write(CMD_A, cmd);
    for (int k = 1; k <= N + 1; k++) begin
      check($sformatf("wave_k%0d", k), pins(), model_pins(cmd, k));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_vec(input logic [31:0] cmd, input logic [7:0] din,
                        input logic [7:0] exp_res, input logic [31:0] exp_rb);
    z80_data_bus_in = din;
    run_cmd(cmd);
    bus_read_check("status_done", STAT_A, 32'd2);
    bus_read_check("cmd_rb", CMD_A, exp_rb);
    bus_read_check("result", RES_A, {24'd0, exp_res});
    bus_read_check("status_clr", STAT_A, 32'd0);
  endtask

  initial begin
    logic [31:0] rc;
    logic [7:0]  rd;

    table_v[0] = '{32'h0001_5A80, 8'h00, 8'h00, 32'h0001_5A80};
    table_v[1] = '{32'h0000_0081, 8'hC3, 8'hC3, 32'h0000_0081};
    table_v[2] = '{32'h0001_3311, 8'h77, 8'hC3, 32'h0001_3311};
    table_v[3] = '{32'hFFFE_FF42, 8'h3C, 8'h3C, 32'h0000_FF42};
    table_v[4] = '{32'h0000_00FF, 8'h00, 8'h00, 32'h0000_00FF};
    table_v[5] = '{32'h0001_A580, 8'h5B, 8'h00, 32'h0001_A580};

    reset = 1'b1;
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
    wb_addr_in = 32'd0; wb_data_in = 32'd0; z80_data_bus_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pins", pins(), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b1}));
    check("rst_ack", 32'(wb_ack_out), 32'd0);
    check("rst_rdata", wb_data_out, 32'd0);
    check("stall", 32'(wb_stall_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    bus_read_check("rst_status", STAT_A, 32'd0);
    bus_read_check("rst_result", RES_A, 32'd0);

    for (int i = 0; i < 6; i++)
      do_vec(table_v[i].cmd, table_v[i].din, table_v[i].exp_result, table_v[i].exp_cmd_rb);
    check("loopback_periph", 32'(periph_reg), 32'h0000_00A5);

    model_result = 8'h00;
    for (int i = 0; i < 25; i++) begin
      rc = $urandom;
      rd = 8'($urandom);
      if (!rc[16]) model_result = rd;
      do_vec(rc, rd, model_result, {15'd0, rc[16:0]});
    end

    // Overrun: second command during SETUP is dropped, first runs unchanged.
    wb_write(CMD_A, 32'h0001_1122);
    @(posedge clk); #1;
    wb_write(CMD_A, 32'h0000_0033);
    check("ovr_k3", pins(), model_pins(32'h0001_1122, 3));
    repeat (N) @(posedge clk);
    #1;
    check("ovr_after", pins(), model_pins(32'h0001_1122, N + 1));
    bus_read_check("ovr_status", STAT_A, 32'd6);
    // Unmapped read: no ack and read data stays at the last STATUS value.
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b0; wb_addr_in = UNM_A;
    @(posedge clk); #1;
    check("unm_ack", 32'(wb_ack_out), 32'd0);
    check("unm_data", wb_data_out, 32'd6);
    wb_cyc_in = 1'b0; wb_addr_in = STAT_A;
    @(posedge clk); #1;
    check("nocyc_ack", 32'(wb_ack_out), 32'd0);
    wb_stb_in = 1'b0;
    bus_read_check("ovr_cmd_rb", CMD_A, 32'h0001_1122);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(wb_ack_out), 32'd0);
    wb_write(STAT_A, 32'h4);
    bus_read_check("ovr_cleared", STAT_A, 32'd2);

    // Back-to-back: command written in the cycle right after done sets.
    wb_write(CMD_A, 32'h0001_4480);
    repeat (N) @(posedge clk);
    #1;
    wb_write(CMD_A, 32'h0000_0055);
    check("b2b_k1", pins(), model_pins(32'h0000_0055, 1));
    repeat (S) @(posedge clk);
    #1;
    check("b2b_k3", pins(), model_pins(32'h0000_0055, S + 1));
    repeat (N) @(posedge clk);
    #1;
    bus_read_check("b2b_status", STAT_A, 32'd2);
    check("b2b_periph", 32'(periph_reg), 32'h0000_0044);

    // RESULT read on the same edge that sets done: set wins.
    z80_data_bus_in = 8'h6E;
    wb_write(CMD_A, 32'h0000_0012);
    repeat (N - 1) @(posedge clk);
    #1;
    bus_read_check("race_result", RES_A, 32'h6E);
    bus_read_check("race_status", STAT_A, 32'd2);
    bus_read_check("race_result2", RES_A, 32'h6E);
    bus_read_check("race_status2", STAT_A, 32'd0);

    // Reset in the middle of a write strobe.
    wb_write(CMD_A, 32'h0001_7720);
    repeat (S + 1) @(posedge clk);
    #1;
    check("mid_strobe", pins(), model_pins(32'h0001_7720, S + 2));
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ws", 32'(z80_write_strobe_b), 32'd1);
    check("rst_mid_dir", 32'(z80_bus_dir), 32'd0);
    reset = 1'b0;
    repeat (T) @(posedge clk);
    #1;
    check("rst_mid_quiet", pins(), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b1}));
    bus_read_check("rst_mid_status", STAT_A, 32'd0);
    bus_read_check("rst_mid_result", RES_A, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
